fetch_seq: RTL and testbench

- Instruction-fetch sequencer for the 16-bit core.
- Owns the program counter, drives the ROM address, and registers fetched words into the opcode output with a valid flag.
- Handles taken branches with a one-cycle flush bubble, halts on a halt opcode, resumes on request, and counts issued instructions.
- Sits between the core's decode/branch logic and the instruction ROM; it replaces free-running PC increment with a controlled sequence.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/pc_unit.sv | 42 ++++
 rtl/fetch_seq.sv | 120 ++++++++++++
 tb/tb_fetch_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction-fetch sequencer.
//   fetch_state_e : sequencer FSM states
//   DefResetPc    : default PC loaded on reset
//   DefHaltOp     : default opcode that stops fetch
//   CountW        : width of the issued-instruction counter
package fetch_pkg;

    typedef enum logic [1:0] {
        StStart,
        StFetch,
        StFlush,
        StHalt
    } fetch_state_e;

    localparam int unsigned DefResetPc = 0;
    localparam logic [15:0] DefHaltOp  = 16'hFFFF;
    localparam int unsigned CountW     = 16;

endpackage

// File: rtl/pc_unit.sv
// Program counter register with load / increment / hold control.
//   clk, rst_n : clock, asynchronous active-low reset (loads RESET_PC)
//   load       : take target on the next edge (wins over inc)
//   inc        : advance by one, wrapping modulo 2^ADDR_W
//   target     : load value
//   pc         : current program counter
module pc_unit
    import fetch_pkg::*;
#(
    parameter int unsigned          ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(DefResetPc)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_d, pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = target;
        end else if (inc) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, drives the ROM address, registers fetched
// words with a valid strobe, inserts a one-cycle bubble on taken branches, halts on the
// halt opcode until resume, and counts issued instructions (saturating).
//   clk, rst_n          : clock, asynchronous active-low reset
//   en                  : global enable; all state holds when low
//   br, br_target       : taken-branch request and destination
//   resume              : leave the halted state
//   rom_addr, rom_data  : ROM address (== pc) and combinational read data
//   opcode, opcode_valid: registered instruction and its one-cycle issue strobe
//   pc, halted          : current PC, halted status
//   instr_count         : issued-instruction count
module fetch_seq
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DefResetPc),
    parameter logic [DATA_W-1:0] HALT_OP  = DATA_W'(DefHaltOp)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              br,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              resume,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] opcode,
    output logic              opcode_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [CountW-1:0] instr_count
);

    fetch_state_e      state_d, state_q;
    logic [DATA_W-1:0] opcode_d, opcode_q;
    logic              valid_d, valid_q;
    logic              halted_d, halted_q;
    logic [CountW-1:0] count_d, count_q;
    logic              pc_load, pc_inc;

    pc_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (pc_load),
        .inc    (pc_inc),
        .target (br_target),
        .pc     (pc)
    );

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        count_d  = count_q;
        pc_load  = 1'b0;
        pc_inc   = 1'b0;

        if (en) begin
            // Strobe: only the issuing FETCH branch below raises it again.
            valid_d = 1'b0;
            unique case (state_q)
                StStart: state_d = StFetch;
                StFetch: begin
                    if (br) begin
                        pc_load = 1'b1;
                        state_d = StFlush;
                    end else if (rom_data == HALT_OP) begin
                        // Skip past the halt word so resume continues after it.
                        pc_inc   = 1'b1;
                        halted_d = 1'b1;
                        state_d  = StHalt;
                    end else begin
                        opcode_d = rom_data;
                        valid_d  = 1'b1;
                        pc_inc   = 1'b1;
                        if (count_q != {CountW{1'b1}}) begin
                            count_d = count_q + CountW'(1);
                        end
                    end
                end
                StFlush: state_d = StFetch;
                StHalt: begin
                    if (resume) begin
                        halted_d = 1'b0;
                        state_d  = StFetch;
                    end
                end
                default: state_d = StStart;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StStart;
            opcode_q <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    assign rom_addr     = pc;
    assign opcode       = opcode_q;
    assign opcode_valid = valid_q;
    assign halted       = halted_q;
    assign instr_count  = count_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: a vector table, directed multi-cycle sequences and a
// randomized run, all compared against a cycle-level behavioural model of the sequencer.
module tb_fetch_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        br = 1'b0;
    logic        resume = 1'b0;
    logic [7:0]  br_target = 8'h00;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] opcode;
    logic        opcode_valid;
    logic [7:0]  pc;
    logic        halted;
    logic [15:0] instr_count;

    logic [15:0] rom [256];
    assign rom_data = rom[rom_addr];

    int n_checks = 0;
    int n_pass   = 0;

    fetch_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .br           (br),
        .br_target    (br_target),
        .resume       (resume),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .opcode       (opcode),
        .opcode_valid (opcode_valid),
        .pc           (pc),
        .halted       (halted),
        .instr_count  (instr_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: bubbles still owed, halted flag, and the issue history.
    logic [7:0]  m_pc;
    int          m_bubble;
    bit          m_halted;
    int          m_count;
    logic [15:0] m_op;
    bit          m_valid;

    task automatic model_reset();
        m_pc = 8'h00; m_bubble = 1; m_halted = 0; m_count = 0; m_op = 16'h0000; m_valid = 0;
    endtask

    task automatic model_step();
        if (en) begin
            m_valid = 0;
            if (m_halted) begin
                if (resume) m_halted = 0;
            end else if (m_bubble > 0) begin
                m_bubble = m_bubble - 1;
            end else if (br) begin
                m_pc = br_target;
                m_bubble = 1;
            end else if (rom[m_pc] == 16'hFFFF) begin
                m_pc = m_pc + 8'd1;
                m_halted = 1;
            end else begin
                m_op = rom[m_pc];
                m_valid = 1;
                m_pc = m_pc + 8'd1;
                if (m_count < 65535) m_count = m_count + 1;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_model();
        check("pc", 32'(pc), 32'(m_pc));
        check("rom_addr", 32'(rom_addr), 32'(m_pc));
        check("opcode", 32'(opcode), 32'(m_op));
        check("opcode_valid", 32'(opcode_valid), 32'(m_valid));
        check("halted", 32'(halted), 32'(m_halted));
        check("instr_count", 32'(instr_count), 32'(m_count));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    // Drops reset between edges and checks the immediate (asynchronous) effect.
    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_opcode", 32'(opcode), 32'h0);
        check("rst_valid", 32'(opcode_valid), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_count", 32'(instr_count), 32'h0);
        check_model();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        en;
        logic        br;
        logic [7:0]  tgt;
        logic        resume;
        logic [15:0] op;
        logic        v;
        logic [7:0]  pc;
        logic        h;
        logic [15:0] cnt;
    } vec_t;

    function automatic vec_t mk(input logic e, input logic b, input logic [7:0] t,
                                input logic r, input logic [15:0] o, input logic v,
                                input logic [7:0] p, input logic h, input logic [15:0] c);
        vec_t x;
        x.en = e; x.br = b; x.tgt = t; x.resume = r;
        x.op = o; x.v = v; x.pc = p; x.h = h; x.cnt = c;
        return x;
    endfunction

    vec_t tbl [15];

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = {8'h5A, 8'(a)};
        rom[0] = 16'h1111; rom[1] = 16'h2222; rom[2] = 16'h3333; rom[3] = 16'h4444;
        rom[5] = 16'hFFFF; rom[8'h10] = 16'hFFFF;
        rom[8'h77] = 16'hFFFF; rom[8'hC3] = 16'hFFFF;

        // Straight line, enable stall (inputs ignored), halt with ignored branch, resume.
        tbl[0]  = mk(1, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 16'd0);
        tbl[1]  = mk(1, 0, 8'h00, 0, 16'h1111, 1, 8'h01, 0, 16'd1);
        tbl[2]  = mk(1, 0, 8'h00, 0, 16'h2222, 1, 8'h02, 0, 16'd2);
        tbl[3]  = mk(1, 0, 8'h00, 0, 16'h3333, 1, 8'h03, 0, 16'd3);
        tbl[4]  = mk(1, 0, 8'h00, 0, 16'h4444, 1, 8'h04, 0, 16'd4);
        tbl[5]  = mk(0, 1, 8'h33, 1, 16'h4444, 1, 8'h04, 0, 16'd4);
        tbl[6]  = mk(0, 0, 8'h00, 0, 16'h4444, 1, 8'h04, 0, 16'd4);
        tbl[7]  = mk(0, 0, 8'h00, 0, 16'h4444, 1, 8'h04, 0, 16'd4);
        tbl[8]  = mk(1, 0, 8'h00, 0, 16'h5A04, 1, 8'h05, 0, 16'd5);
        tbl[9]  = mk(1, 0, 8'h00, 0, 16'h5A04, 0, 8'h06, 1, 16'd5);
        tbl[10] = mk(1, 1, 8'h20, 0, 16'h5A04, 0, 8'h06, 1, 16'd5);
        tbl[11] = mk(1, 0, 8'h00, 0, 16'h5A04, 0, 8'h06, 1, 16'd5);
        tbl[12] = mk(1, 0, 8'h00, 1, 16'h5A04, 0, 8'h06, 0, 16'd5);
        tbl[13] = mk(1, 0, 8'h00, 0, 16'h5A06, 1, 8'h07, 0, 16'd6);
        tbl[14] = mk(1, 0, 8'h00, 0, 16'h5A07, 1, 8'h08, 0, 16'd7);

        #2;
        async_reset();

        for (int i = 0; i < 15; i++) begin
            en = tbl[i].en; br = tbl[i].br; br_target = tbl[i].tgt; resume = tbl[i].resume;
            tick();
            check($sformatf("tbl%0d_opcode", i), 32'(opcode), 32'(tbl[i].op));
            check($sformatf("tbl%0d_valid", i), 32'(opcode_valid), 32'(tbl[i].v));
            check($sformatf("tbl%0d_pc", i), 32'(pc), 32'(tbl[i].pc));
            check($sformatf("tbl%0d_halted", i), 32'(halted), 32'(tbl[i].h));
            check($sformatf("tbl%0d_count", i), 32'(instr_count), 32'(tbl[i].cnt));
        end
        en = 1'b1; br = 1'b0; resume = 1'b0;

        // Taken branch while fetching address 2: word 2 never issued, one bubble.
        async_reset();
        tick(); tick(); tick();
        br = 1'b1; br_target = 8'h40;
        tick();
        check("br_bubble_valid", 32'(opcode_valid), 32'h0);
        check("br_pc", 32'(pc), 32'h40);
        br_target = 8'h80;  // still high during the flush: must be ignored
        tick();
        check("br_flush_pc", 32'(pc), 32'h40);
        br = 1'b0;
        tick();
        check("br_target_op", 32'(opcode), 32'h5A40);
        check("br_target_valid", 32'(opcode_valid), 32'h1);
        check("br_after_pc", 32'(pc), 32'h41);

        // PC wrap: 0xFF then 0x00.
        br = 1'b1; br_target = 8'hFE;
        tick();
        br = 1'b0;
        tick(); tick(); tick();
        check("wrap_ff_op", 32'(opcode), 32'h5AFF);
        check("wrap_pc", 32'(pc), 32'h00);
        tick();
        check("wrap_00_op", 32'(opcode), 32'h1111);

        // Branch beats halt when both present on the same fetch.
        br = 1'b1; br_target = 8'h10;
        tick();
        br = 1'b0;
        tick();
        br = 1'b1; br_target = 8'h30;
        tick();
        check("prio_halted", 32'(halted), 32'h0);
        check("prio_pc", 32'(pc), 32'h30);
        br = 1'b0;

        // Reach HALT with seven issued instructions, hold it, then reset mid-HALT.
        async_reset();
        tick();
        br = 1'b1; br_target = 8'h09;
        tick();
        br = 1'b0;
        tick();
        repeat (7) tick();
        tick();
        check("halt7_halted", 32'(halted), 32'h1);
        check("halt7_count", 32'(instr_count), 32'd7);
        for (int k = 0; k < 10; k++) begin
            br = k[0]; br_target = 8'h22;
            tick();
            check("halt_hold_valid", 32'(opcode_valid), 32'h0);
            check("halt_hold_pc", 32'(pc), 32'h11);
        end
        br = 1'b0;
        #2;
        async_reset();
        tick(); tick();
        check("restart_op", 32'(opcode), 32'h1111);
        check("restart_pc", 32'(pc), 32'h01);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            en        = ($urandom_range(0, 9) < 8);
            br        = ($urandom_range(0, 9) == 0);
            resume    = ($urandom_range(0, 9) < 3);
            br_target = 8'($urandom_range(0, 255));
            tick();
            if ($urandom_range(0, 199) == 0) async_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
